// File: rtl/rx_word_fifo.sv
// UART byte-to-word assembler feeding a first-word fall-through word FIFO.
// Optional sticky overflow flag built when RX_WORD_FIFO_OVERFLOW_EN is defined.
module rx_word_fifo #(
  parameter int WIDTH      = 12,
  parameter int WORD_BYTES = 4
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    flush,
  input  logic                    ready,
  output logic [8*WORD_BYTES-1:0] out,
  output logic                    valid,
  output logic [WIDTH:0]          count,
  output logic                    overflow
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int LW = (WORD_BYTES > 1) ? WORD_BYTES - 1 : 1;
  localparam int DEPTH = 1 << WIDTH;
  localparam logic [WIDTH:0] FULL = (WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);

  logic [IW-1:0]    idx;
  logic [7:0]       lane [LW];
  logic [DW-1:0]    word;
  logic [DW-1:0]    mem [DEPTH];
  logic [WIDTH-1:0] wptr;
  logic [WIDTH-1:0] rptr;
  logic [WIDTH:0]   cnt;
  logic             done;
  logic             full;
  logic             pop;
  logic             push;

  // Last byte goes straight from in_data so the word is pushed on its own edge.
  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    if (g == WORD_BYTES - 1) begin : g_top
      assign word[8*g +: 8] = in_data;
    end else begin : g_reg
      assign word[8*g +: 8] = lane[g];
    end
  end

  assign done  = in_valid && (idx == LAST) && !flush;
  assign full  = (cnt == FULL);
  assign valid = (cnt != '0);
  assign pop   = valid && ready && !flush;
  assign push  = done && (!full || pop);
  assign out   = mem[rptr];
  assign count = cnt;

  always_ff @(posedge CLK) begin
    if (in_valid && !flush && (idx != LAST))
      lane[idx] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wptr] <= word;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idx  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      idx  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (in_valid)
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      if (push)
        wptr <= wptr + WIDTH'(1);
      if (pop)
        rptr <= rptr + WIDTH'(1);
      unique case (1'b1)
        push && !pop: cnt <= cnt + (WIDTH+1)'(1);
        pop && !push: cnt <= cnt - (WIDTH+1)'(1);
        default:      cnt <= cnt;
      endcase
    end
  end

`ifdef RX_WORD_FIFO_OVERFLOW_EN
  logic ovf;
  logic reject;

  assign reject   = done && full && !pop;
  assign overflow = ovf;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      ovf <= 1'b0;
    else if (flush)
      ovf <= 1'b0;
    else if (reject)
      ovf <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/rx_word_fifo.md
RX_WORD_FIFO -- requirements
Module: rx_word_fifo

Interface
REQ-001 Parameter WIDTH, default 12: log2 of FIFO depth in words; depth = 2**WIDTH.
REQ-002 Parameter WORD_BYTES, default 4: bytes per assembled word; legal values 1, 2, 4.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  8  byte from UART receiver.
REQ-006 in_valid  input  1  single-cycle strobe; in_data valid this cycle.
REQ-007 flush  input  1  synchronous clear of FIFO, assembler and overflow flag.
REQ-008 ready  input  1  consumer accepts the head word this cycle.
REQ-009 out  output  8*WORD_BYTES  head word of FIFO.
REQ-010 valid  output  1  FIFO non-empty; out is meaningful.
REQ-011 count  output  WIDTH+1  number of words stored, 0..2**WIDTH.
REQ-012 overflow  output  1  sticky: a completed word was dropped.

Function
REQ-013 Assembler: byte index register 0..WORD_BYTES-1; each in_valid places in_data in lane index (little-endian: first byte at bits 7:0) and increments the index.
REQ-014 When in_valid carries lane WORD_BYTES-1, the completed word is pushed at that clock edge and the index returns to 0.
REQ-015 A partial word is held indefinitely; it never appears on out and is not counted.
REQ-016 WORD_BYTES=1: every in_valid byte is pushed directly (plain byte FIFO).
REQ-017 Storage: 2**WIDTH words, distributed RAM, separate read/write pointers of WIDTH bits wrapping modulo 2**WIDTH.
REQ-018 valid = (count != 0); out = storage[read pointer], combinational, first-word fall-through.
REQ-019 Pop occurs on any edge where valid && ready; ready while valid=0 has no effect.
REQ-020 Latency: word completed at edge N is visible (valid=1, out correct) immediately after edge N; no bypass within the same cycle.
REQ-021 Push accepted when count < 2**WIDTH, or when count = 2**WIDTH and a pop occurs on the same edge.
REQ-022 Simultaneous push and pop: both take effect; count unchanged.
REQ-023 count increments on push-only, decrements on pop-only, never exceeds 2**WIDTH nor underflows.
REQ-024 Rejected push (full, no pop): word discarded, pointers and count unchanged, assembler index still returns to 0.
REQ-025 flush=1 at an edge: pointers, count, assembler index and overflow cleared; in_valid and ready in that cycle ignored; storage contents untouched.

Reset
REQ-026 RSTN low asynchronously clears pointers, count, assembler index and overflow; valid=0, count=0, overflow=0 while RSTN low.
REQ-027 out is unspecified while valid=0; storage and lane registers are not reset.
REQ-028 Reset mid-word discards the partial word; first byte after release is lane 0.
REQ-029 Release of RSTN is synchronised by the caller; the block samples inputs from the first posedge after release.

Configuration
REQ-030 Macro RX_WORD_FIFO_OVERFLOW_EN defined: overflow set on any rejected push (REQ-024), held until flush or reset.
REQ-031 Macro undefined: overflow tied to 0, no flag register built; rejected pushes still dropped silently.

Verification
REQ-032 WORD_BYTES=4: bytes 0x11,0x22,0x33,0x44 on four in_valid strobes, ready=0 -> after 4th edge valid=1, out=0x44332211, count=1.
REQ-033 WIDTH=2: push 4 words then a 5th, ready=0 -> count=4, 5th dropped, overflow=1 (macro defined) / 0 (undefined); head still word 1.
REQ-034 WIDTH=2 full, 5th word completes with ready=1 same cycle -> pop and push both occur, count=4, new word is last out after 4 pops.
REQ-035 Stream 10 words through WIDTH=2 with ready toggling every cycle -> words out in order across pointer wrap, count never >4, no overflow.
REQ-036 Two bytes of a word sent, then RSTN pulsed low mid-cycle -> valid=0, count=0 immediately; next 4 bytes 0xA0..0xA3 give out=0xA3A2A1A0.
REQ-037 count=3, overflow=1, flush=1 with in_valid completing a word -> next cycle count=0, valid=0, overflow=0, word not stored.
